// File: rtl/dma_stream_gen.sv
// Splits one DMA descriptor into AXI-legal address-channel burst requests.
// Latency: start handshake at T -> first req_valid at T+2; empty descriptor -> done at T+2.
// Backpressure: req_* held while req_ready low; issue also throttled by MAX_OUTST credits.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_*             descriptor handshake (start_ready high only when idle)
//   abort               level; stop issuing, let outstanding bursts drain, then finish
//   maxb                CSR burst length limit, beats-1
//   req_*               burst request (addr, alen, size, fixed, strb) with valid/ready
//   cmpl_valid          one burst completed downstream
//   outst               bursts issued but not yet completed
//   done / aborted      end-of-descriptor pulse, with aborted status
module dma_stream_gen #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 32,
  parameter int MAX_BEATS = 256,
  parameter int MAX_OUTST = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_valid,
  output logic                             start_ready,
  input  logic [ADDR_W-1:0]                start_addr,
  input  logic [LEN_W-1:0]                 start_bytes,
  input  logic                             start_fixed,
  input  logic                             abort,
  input  logic [7:0]                       maxb,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [ADDR_W-1:0]                req_addr,
  output logic [7:0]                       req_alen,
  output logic [2:0]                       req_size,
  output logic                             req_fixed,
  output logic [DATA_W/8-1:0]              req_strb,
  input  logic                             cmpl_valid,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst,
  output logic                             done,
  output logic                             aborted
);
  localparam int BUS_B = DATA_W / 8;
  localparam int LOG_B = $clog2(BUS_B);
  localparam int SB_W  = LOG_B + 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W-1:0]   remain;     // bytes not yet loaded into a request
  logic               cur_fixed;
  logic               abort_seen;

  // Next-chunk computation from the current address / remaining count
  logic [LOG_B-1:0]   off;
  logic [SB_W-1:0]    room_b;     // bytes from off to end of the bus word
  logic [12:0]        room_4k;    // bytes to the next 4 KiB boundary
  logic [12:0]        cap;        // max beats allowed for an aligned burst
  logic [LEN_W-1:0]   rbeats;
  logic [12:0]        c_beats;
  logic [LEN_W-1:0]   c_bytes;
  logic [SB_W-1:0]    sb_n;       // valid bytes in the first beat
  logic [BUS_B-1:0]   c_strb;

  assign off = cur_addr[LOG_B-1:0];

  always_comb begin
    room_b  = SB_W'(BUS_B) - {1'b0, off};
    room_4k = 13'h1000 - {1'b0, cur_addr[11:0]};
    cap     = 13'(MAX_BEATS);
    if (({5'b0, maxb} + 13'd1) < cap) cap = {5'b0, maxb} + 13'd1;
    if ((room_4k >> LOG_B) < cap)     cap = room_4k >> LOG_B;
    if (cur_fixed && (cap > 13'd16))  cap = 13'd16;
    rbeats  = remain >> LOG_B;
    // Unaligned start or a sub-word tail: single partial beat, clipped to the word end
    if ((off != '0) || (remain < LEN_W'(BUS_B))) begin
      c_beats = 13'd1;
      c_bytes = (remain < LEN_W'(room_b)) ? remain : LEN_W'(room_b);
      sb_n    = c_bytes[SB_W-1:0];
    end else begin
      c_beats = (rbeats < LEN_W'(cap)) ? rbeats[12:0] : cap;
      c_bytes = LEN_W'(c_beats) << LOG_B;
      sb_n    = SB_W'(BUS_B);
    end
  end

  always_comb begin
    c_strb = '0;
    for (int i = 0; i < BUS_B; i++)
      c_strb[i] = (i >= int'(off)) && (i < int'(off) + int'(sb_n));
  end

  // Handshake, credit and issue decisions for this cycle
  logic             hs, cmpl_eff, load, req_pend_nxt, run_end, abort_hit;
  logic [OUT_W-1:0] outst_nxt;
  logic [LEN_W-1:0] remain_nxt;

  assign start_ready  = (state == IDLE);
  assign hs           = req_valid & req_ready;
  assign cmpl_eff     = cmpl_valid & (outst != '0);
  assign outst_nxt    = outst + OUT_W'(hs) - OUT_W'(cmpl_eff);
  // Credit check uses post-cycle occupancy so a handshake or completion this cycle
  // lets the next request follow without a bubble.
  assign load         = (state == RUN) & (~req_valid | req_ready) & (remain != '0) &
                        ~abort & (outst_nxt < OUT_W'(MAX_OUTST));
  assign remain_nxt   = load ? (remain - c_bytes) : remain;
  assign req_pend_nxt = load | (req_valid & ~req_ready);
  assign run_end      = ~req_pend_nxt & ((remain_nxt == '0) | abort);
  // Abort only counts while work is still unissued or a request is still pending
  assign abort_hit    = abort & ((remain != '0) | req_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remain     <= '0;
      cur_fixed  <= 1'b0;
      abort_seen <= 1'b0;
      req_valid  <= 1'b0;
      req_addr   <= '0;
      req_alen   <= '0;
      req_size   <= '0;
      req_fixed  <= 1'b0;
      req_strb   <= '0;
      outst      <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done  <= 1'b0;
      outst <= outst_nxt;
      if (hs) req_valid <= 1'b0;
      if (load) begin
        req_valid <= 1'b1;
        req_addr  <= {cur_addr[ADDR_W-1:LOG_B], LOG_B'(0)};
        req_alen  <= 8'(c_beats - 13'd1);
        req_size  <= 3'(LOG_B);
        req_fixed <= cur_fixed;
        req_strb  <= c_strb;
        remain    <= remain_nxt;
        if (!cur_fixed) cur_addr <= cur_addr + ADDR_W'(c_bytes);
      end
      case (state)
        IDLE: begin
          if (start_valid) begin
            cur_addr   <= start_addr;
            remain     <= start_bytes;
            cur_fixed  <= start_fixed;
            abort_seen <= 1'b0;
            aborted    <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (abort_hit) abort_seen <= 1'b1;
          if (run_end) begin
            // Skip DRAIN when nothing is outstanding so an empty descriptor ends at T+2
            if (outst_nxt == '0) begin
              state   <= IDLE;
              done    <= 1'b1;
              aborted <= abort_seen | abort_hit;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort_hit) abort_seen <= 1'b1;
          if (outst_nxt == '0) begin
            state   <= IDLE;
            done    <= 1'b1;
            aborted <= abort_seen | abort_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_stream_gen.sv
module tb_dma_stream_gen;
  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 32;
  localparam int MAX_BEATS = 64;
  localparam int MAX_OUTST = 2;
  localparam int OW        = $clog2(MAX_OUTST + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_valid, start_ready, start_fixed, abort;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_bytes;
  logic [7:0]        maxb;
  logic              req_valid, req_ready, req_fixed;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_alen;
  logic [2:0]        req_size;
  logic [31:0]       req_strb;
  logic              cmpl_valid;
  logic [OW-1:0]     outst;
  logic              done, aborted;

  always #5 clk = ~clk;

  dma_stream_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
                   .MAX_BEATS(MAX_BEATS), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_addr(start_addr),
    .start_bytes(start_bytes), .start_fixed(start_fixed), .abort(abort), .maxb(maxb),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_alen(req_alen),
    .req_size(req_size), .req_fixed(req_fixed), .req_strb(req_strb),
    .cmpl_valid(cmpl_valid), .outst(outst), .done(done), .aborted(aborted)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [31:0] strb;
    logic        fx;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] bytes;
    logic        fx;
    logic [7:0]  maxb;
    int          nreq;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] s0;
  } vec_t;

  req_t exp_q[$];
  vec_t vecs[10];
  int   n_vec = 0, n_miss = 0;
  int   hs_cnt = 0, cmpl_cnt = 0, done_cnt = 0, vec_hs = 0;
  logic last_ab = 1'b0;
  bit   rdy_rand = 1'b0, cmpl_auto = 1'b0;
  logic rdy_force = 1'b0, cmpl_force = 1'b0;
  req_t first_req, prev_req;
  logic prev_stall = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference chunking: expected request sequence for one descriptor (BUS_B = 32)
  task automatic push_model(input logic [31:0] a, input logic [31:0] r, input logic fx,
                            input logic [7:0] mb);
    longint A, R, off, n, beats, lim;
    logic [63:0] m;
    req_t e;
    A = a; R = r;
    while (R > 0) begin
      off = A % 32;
      if (off != 0 || R < 32) begin
        n = (32 - off < R) ? 32 - off : R;
        beats = 1;
        m = ((64'd1 << n) - 64'd1) << off;
      end else begin
        beats = R / 32;
        if (beats > MAX_BEATS) beats = MAX_BEATS;
        if (beats > int'(mb) + 1) beats = int'(mb) + 1;
        lim = (4096 - (A % 4096)) / 32;
        if (beats > lim) beats = lim;
        if (fx && beats > 16) beats = 16;
        n = beats * 32;
        m = 64'hFFFF_FFFF;
      end
      e.addr = 32'(A - off);
      e.alen = 8'(beats - 1);
      e.strb = m[31:0];
      e.fx   = fx;
      exp_q.push_back(e);
      R = R - n;
      if (!fx) A = (A + n) % 64'h1_0000_0000;
    end
  endtask

  // One clock cycle. Called at the falling edge: drive ready/cmpl, observe, advance.
  task automatic tick();
    req_t got, want;
    if (rdy_rand) req_ready = 1'($urandom_range(0, 1));
    else          req_ready = rdy_force;
    if (cmpl_auto) cmpl_valid = (hs_cnt > cmpl_cnt) && ($urandom_range(0, 2) != 0);
    else           cmpl_valid = cmpl_force;
    if (!rst) begin
      chk("outst", outst, hs_cnt - cmpl_cnt);
      if (prev_stall) begin
        chk("held_valid", req_valid, 1);
        chk("held_addr", req_addr, prev_req.addr);
        chk("held_alen", req_alen, prev_req.alen);
        chk("held_strb", req_strb, prev_req.strb);
      end
      if (cmpl_valid && hs_cnt > cmpl_cnt) cmpl_cnt++;
      if (req_valid && req_ready) begin
        got = '{req_addr, req_alen, req_strb, req_fixed};
        if (vec_hs == 0) first_req = got;
        vec_hs++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_req: got addr 0x%0h alen %0d, expected none", req_addr, req_alen);
        end else begin
          want = exp_q.pop_front();
          chk("req_addr", req_addr, want.addr);
          chk("req_alen", req_alen, want.alen);
          chk("req_strb", req_strb, want.strb);
          chk("req_fixed", req_fixed, want.fx);
          chk("req_size", req_size, 5);
        end
      end
      if (done) begin
        done_cnt++;
        last_ab = aborted;
      end
      prev_stall = req_valid && !req_ready;
      prev_req   = '{req_addr, req_alen, req_strb, req_fixed};
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    if (rst) cmpl_cnt = hs_cnt;
    @(negedge clk);
  endtask

  task automatic start_desc(input logic [31:0] a, input logic [31:0] b, input logic fx);
    start_addr  = a;
    start_bytes = b;
    start_fixed = fx;
    start_valid = 1'b1;
    vec_hs      = 0;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == base) begin
      n_vec++; n_miss++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    maxb = v.maxb;
    push_model(v.addr, v.bytes, v.fx, v.maxb);
    chk({tag, "_start_ready"}, start_ready, 1);
    start_desc(v.addr, v.bytes, v.fx);
    wait_done(tag, 3000);
    chk({tag, "_nreq"}, vec_hs, v.nreq);
    chk({tag, "_addr0"}, first_req.addr, v.a0);
    chk({tag, "_alen0"}, first_req.alen, v.l0);
    chk({tag, "_strb0"}, first_req.strb, v.s0);
    chk({tag, "_aborted"}, last_ab, 0);
    chk({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int hs0, dbase;
    //           addr        bytes  fx    maxb   n  addr0       alen0  strb0
    vecs[0] = '{32'h1000,   256,   1'b0, 8'd255, 1, 32'h1000, 8'd7,  32'hFFFFFFFF};
    vecs[1] = '{32'h0FE0,   256,   1'b0, 8'd255, 2, 32'h0FE0, 8'd0,  32'hFFFFFFFF};
    vecs[2] = '{32'h1005,   40,    1'b0, 8'd255, 2, 32'h1000, 8'd0,  32'hFFFFFFE0};
    vecs[3] = '{32'h2000,   1024,  1'b1, 8'd255, 2, 32'h2000, 8'd15, 32'hFFFFFFFF};
    vecs[4] = '{32'h4000,   256,   1'b0, 8'd3,   2, 32'h4000, 8'd3,  32'hFFFFFFFF};
    vecs[5] = '{32'h3000,   4096,  1'b0, 8'd255, 2, 32'h3000, 8'd63, 32'hFFFFFFFF};
    vecs[6] = '{32'h5003,   3,     1'b0, 8'd255, 1, 32'h5000, 8'd0,  32'h00000038};
    vecs[7] = '{32'h6000,   31,    1'b0, 8'd255, 1, 32'h6000, 8'd0,  32'h7FFFFFFF};
    vecs[8] = '{32'h7010,   100,   1'b0, 8'd255, 3, 32'h7000, 8'd0,  32'hFFFF0000};
    vecs[9] = '{32'h8000,   64,    1'b0, 8'd0,   2, 32'h8000, 8'd0,  32'hFFFFFFFF};

    start_valid = 1'b0; start_addr = '0; start_bytes = '0; start_fixed = 1'b0;
    abort = 1'b0; maxb = 8'd255; req_ready = 1'b0; cmpl_valid = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_alen", req_alen, 0);
    chk("rst_req_strb", req_strb, 0);
    chk("rst_outst", outst, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_start_ready", start_ready, 1);
    rst = 1'b0;
    tick();

    // Table vectors with random backpressure and completions
    rdy_rand = 1'b1;
    cmpl_auto = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    rdy_rand = 1'b0;
    cmpl_auto = 1'b0;
    rdy_force = 1'b0;
    cmpl_force = 1'b0;

    // Empty descriptor: no requests, done exactly two cycles after the handshake
    maxb = 8'd255;
    hs0 = hs_cnt;
    start_desc(32'h9000, 0, 1'b0);
    chk("zero_t1_done", done, 0);
    chk("zero_t1_valid", req_valid, 0);
    tick();
    chk("zero_t2_done", done, 1);
    chk("zero_t2_aborted", aborted, 0);
    tick();
    chk("zero_nreq", hs_cnt - hs0, 0);

    // First-request latency, then abort while the request is stalled
    maxb = 8'd7;
    exp_q.push_back('{32'h1000, 8'd7, 32'hFFFFFFFF, 1'b0});
    start_desc(32'h1000, 512, 1'b0);
    chk("lat_t1_valid", req_valid, 0);
    tick();
    chk("lat_t2_valid", req_valid, 1);
    chk("lat_t2_addr", req_addr, 32'h1000);
    chk("lat_t2_alen", req_alen, 7);
    abort = 1'b1;
    repeat (3) tick();
    chk("abort_held_valid", req_valid, 1);
    rdy_force = 1'b1;
    tick();
    rdy_force = 1'b0;
    repeat (3) begin
      chk("abort_no_new_req", req_valid, 0);
      chk("abort_no_early_done", done, 0);
      tick();
    end
    chk("abort_outst", outst, 1);
    cmpl_force = 1'b1;
    tick();
    cmpl_force = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_aborted", aborted, 1);
    chk("abort_leftover", exp_q.size(), 0);
    tick();
    chk("abort_idle_ignored", start_ready, 1);
    chk("abort_idle_no_done", done, 0);
    abort = 1'b0;
    exp_q.delete();

    // Outstanding limit: 4 bursts, ready held high, completions held off
    maxb = 8'd7;
    push_model(32'h1000, 1024, 1'b0, 8'd7);
    rdy_force = 1'b1;
    hs0 = hs_cnt;
    start_desc(32'h1000, 1024, 1'b0);
    repeat (6) tick();
    chk("credit_hs2", hs_cnt - hs0, 2);
    chk("credit_stop_valid", req_valid, 0);
    chk("credit_outst", outst, 2);
    cmpl_force = 1'b1;
    tick();
    cmpl_force = 1'b0;
    repeat (4) tick();
    chk("credit_hs3", hs_cnt - hs0, 3);
    chk("credit_stop_valid2", req_valid, 0);
    cmpl_auto = 1'b1;
    wait_done("credit", 500);
    chk("credit_nreq", hs_cnt - hs0, 4);
    chk("credit_aborted_cleared", last_ab, 0);
    chk("credit_leftover", exp_q.size(), 0);
    exp_q.delete();
    cmpl_auto = 1'b0;
    rdy_force = 1'b0;

    // Reset while a request is pending: immediate idle, no done
    maxb = 8'd255;
    start_desc(32'h1000, 256, 1'b0);
    tick();
    chk("rstrun_pre_valid", req_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrun_valid", req_valid, 0);
    chk("rstrun_outst", outst, 0);
    chk("rstrun_ready", start_ready, 1);
    dbase = done_cnt;
    repeat (5) tick();
    chk("rstrun_no_done", done_cnt - dbase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
